// File: rtl/pe_dot_pack_mac_if.sv
// Beat/result bus between the feature/filter streamers, the packed dot MAC and the PE output drain.
// The streamers drive the beat side (master); the MAC drives the result side (slave).
interface pe_dot_pack_mac_if #(
  parameter int DOT_SIZE  = 4,
  parameter int MAG_WIDTH = 3,
  parameter int ACC_WIDTH = 16
);
  localparam int OPW = 2 * DOT_SIZE * (MAG_WIDTH + 1);

  logic                   i_valid;
  logic                   i_first;
  logic                   i_last;
  logic [OPW-1:0]         i_feature;
  logic [OPW-1:0]         i_filter;
  logic                   o_valid;
  logic [4*ACC_WIDTH-1:0] o_sum;
  logic                   o_sat;
  logic [15:0]            o_beats;

  modport master (
    output i_valid, i_first, i_last, i_feature, i_filter,
    input  o_valid, o_sum, o_sat, o_beats
  );

  modport slave (
    input  i_valid, i_first, i_last, i_feature, i_filter,
    output o_valid, o_sum, o_sat, o_beats
  );
endinterface

// File: rtl/pe_dot_pack_mac.sv
// Packed 2x2 sign-magnitude dot MAC: cross products, DOT_SIZE reduction, saturating group accumulation.
// o_valid follows the last beat of a group by MULT_LATENCY+2 cycles; no backpressure, every valid beat is consumed.
module pe_dot_pack_mac #(
  parameter int DOT_SIZE            = 4,
  parameter int MAG_WIDTH           = 3,
  parameter int NUM_PACKED_FEATURES = 2,
  parameter int NUM_PACKED_FILTERS  = 2,
  parameter int MULT_LATENCY        = 2,
  parameter int ACC_WIDTH           = 16
) (
  input logic              clock,
  input logic              resetn,
  pe_dot_pack_mac_if.slave bus
);
  localparam int OW = MAG_WIDTH + 1;
  localparam int PW = 2 * MAG_WIDTH + 1;
  localparam int SW = PW + $clog2(DOT_SIZE);
  localparam int NL = NUM_PACKED_FEATURES * NUM_PACKED_FILTERS;
  localparam logic signed [ACC_WIDTH:0] MAXV = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINV = -MAXV;
  localparam logic [15:0] BEATS_MAX = 16'hFFFF;

  typedef enum logic {IDLE, ACCUM} state_e;

  logic [NL-1:0][DOT_SIZE-1:0][PW-1:0]                   prod_c;
  logic [MULT_LATENCY-1:0][NL-1:0][DOT_SIZE-1:0][PW-1:0] prod_q;
  logic [MULT_LATENCY-1:0] pv_q, pf_q, pl_q;
  logic [NL-1:0][SW-1:0]   sum_c, sum_q;
  logic                    sv_q, sf_q, sl_q;
  logic [NL-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
  logic [NL-1:0]           clamp;
  logic                    sat_q, sat_d;
  logic [15:0]             beats_q, beats_d;
  state_e                  state_q, state_d;
  logic                    restart, emit, acc_en;
  logic                    o_valid_q, o_sat_q;
  logic [NL-1:0][ACC_WIDTH-1:0] o_sum_q;
  logic [15:0]             o_beats_q;

  // Sign-magnitude product: multiply magnitudes, negate on sign mismatch; a zero magnitude stays 0.
  for (genvar l = 0; l < NL; l++) begin : g_lane_prod
    localparam int F = l / NUM_PACKED_FILTERS;
    localparam int K = l % NUM_PACKED_FILTERS;
    for (genvar d = 0; d < DOT_SIZE; d++) begin : g_elem
      logic [OW-1:0]          fo, ko;
      logic [2*MAG_WIDTH-1:0] mp;
      assign fo = bus.i_feature[(F*DOT_SIZE+d)*OW +: OW];
      assign ko = bus.i_filter[(K*DOT_SIZE+d)*OW +: OW];
      assign mp = {{MAG_WIDTH{1'b0}}, fo[MAG_WIDTH-1:0]} * {{MAG_WIDTH{1'b0}}, ko[MAG_WIDTH-1:0]};
      assign prod_c[l][d] = (fo[MAG_WIDTH] ^ ko[MAG_WIDTH]) ? -{1'b0, mp} : {1'b0, mp};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pv_q <= '0;
      pf_q <= '0;
      pl_q <= '0;
      sv_q <= 1'b0;
      sf_q <= 1'b0;
      sl_q <= 1'b0;
    end else begin
      pv_q[0] <= bus.i_valid;
      pf_q[0] <= bus.i_first;
      pl_q[0] <= bus.i_last;
      for (int s = 1; s < MULT_LATENCY; s++) begin
        pv_q[s] <= pv_q[s-1];
        pf_q[s] <= pf_q[s-1];
        pl_q[s] <= pl_q[s-1];
      end
      sv_q <= pv_q[MULT_LATENCY-1];
      sf_q <= pf_q[MULT_LATENCY-1];
      sl_q <= pl_q[MULT_LATENCY-1];
    end
  end

  // Data stages carry no reset; the valid chain alone qualifies them.
  always_ff @(posedge clock) begin
    if (bus.i_valid) prod_q[0] <= prod_c;
    for (int s = 1; s < MULT_LATENCY; s++) prod_q[s] <= prod_q[s-1];
    sum_q <= sum_c;
  end

  always_comb begin
    sum_c = '0;
    for (int l = 0; l < NL; l++)
      for (int d = 0; d < DOT_SIZE; d++)
        sum_c[l] = sum_c[l] + SW'($signed(prod_q[MULT_LATENCY-1][l][d]));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sv_q) state_d = sl_q ? IDLE : ACCUM;
  end

  // A first beat, or any beat arriving in IDLE, opens a fresh group and drops whatever was open.
  always_comb begin
    restart = 1'b0;
    emit    = 1'b0;
    acc_en  = 1'b0;
    if (sv_q) begin
      acc_en  = 1'b1;
      emit    = sl_q;
      restart = (state_q == IDLE) || sf_q;
    end
  end

  for (genvar l = 0; l < NL; l++) begin : g_lane_acc
    logic [ACC_WIDTH-1:0]      base;
    logic signed [ACC_WIDTH:0] wide;
    logic                      hi, lo;
    assign base  = restart ? '0 : acc_q[l];
    assign wide  = $signed({base[ACC_WIDTH-1], base}) + (ACC_WIDTH+1)'($signed(sum_q[l]));
    assign hi    = wide > MAXV;
    assign lo    = wide < MINV;
    assign clamp[l] = hi | lo;
    assign acc_d[l] = hi ? MAXV[ACC_WIDTH-1:0] : (lo ? MINV[ACC_WIDTH-1:0] : wide[ACC_WIDTH-1:0]);
  end

  assign sat_d   = (restart ? 1'b0 : sat_q) | (|clamp);
  assign beats_d = restart ? 16'd1 : ((beats_q == BEATS_MAX) ? beats_q : beats_q + 16'd1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc_q     <= '0;
      sat_q     <= 1'b0;
      beats_q   <= '0;
      o_valid_q <= 1'b0;
      o_sum_q   <= '0;
      o_sat_q   <= 1'b0;
      o_beats_q <= '0;
    end else begin
      o_valid_q <= emit;
      if (acc_en) begin
        acc_q   <= acc_d;
        sat_q   <= sat_d;
        beats_q <= beats_d;
      end
      if (emit) begin
        o_sum_q   <= acc_d;
        o_sat_q   <= sat_d;
        o_beats_q <= beats_d;
      end
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_sum   = o_sum_q;
  assign bus.o_sat   = o_sat_q;
  assign bus.o_beats = o_beats_q;
endmodule
